writeback_stage: RTL and testbench

Commit stage directly downstream of the ALU. It accepts one ALU result per handshake and owns the architectural register file and the NZCV flags register. It performs the memory access for load/store ops through a req/ack port. Its register read ports and flags output feed the ALU's `src1`/`src2` and condition check for the next instruction.

---
 rtl/writeback_stage.sv | 174 +++++++++++++++++
 tb/tb_writeback_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - commit stage: register file, NZCV flags and load/store port (optional WB_FORWARDING_EN bypass)
module writeback_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 16,
  localparam int IDX_W  = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_code_i,
  input  logic [IDX_W-1:0]  dest_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              reg_write_i,
  input  logic [3:0]        flags_in_i,
  input  logic              flags_update_i,
  input  logic [IDX_W-1:0]  rd_addr_a_i,
  input  logic [IDX_W-1:0]  rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic [3:0]        flags_out_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {S_IDLE, S_MEM} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [REG_CNT];
  logic [3:0]          flags_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [IDX_W-1:0]    mem_dest_q;

  logic                is_mem_op;
  logic                op_writes;
  logic                flag_op;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic                flags_wr;
  logic                mem_load;

  // Loads and stores leave for the memory port; compare, store and 1111 never write a register
  assign is_mem_op = (op_code_i == 4'b1101) || (op_code_i == 4'b1110);
  assign op_writes = !(op_code_i inside {4'b1011, 4'b1101, 4'b1110, 4'b1111});
  assign flag_op   = op_code_i inside {4'b0000, 4'b0001, 4'b0010, 4'b1000,
                                       4'b1001, 4'b1010, 4'b1011};

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < (IDX_W+1)'(REG_CNT));
  endfunction

  // Next state plus the single register-file write port and flag commit for this edge
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_idx   = dest_i;
    wr_data  = result_i;
    flags_wr = 1'b0;
    mem_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          flags_wr = flags_update_i & flag_op;
          if (is_mem_op) begin
            state_d  = S_MEM;
            mem_load = 1'b1;
          end else begin
            wr_en = reg_write_i & op_writes;
          end
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          state_d = S_IDLE;
          wr_idx  = mem_dest_q;
          wr_data = mem_rdata_i;
          wr_en   = ~mem_we_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset wins over any commit; out-of-range destinations are dropped
    if (reset_i || !idx_ok(wr_idx)) begin
      wr_en = 1'b0;
    end
    if (reset_i) begin
      flags_wr = 1'b0;
      mem_load = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Architectural register file
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Committed NZCV flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q <= 4'b0000;
    end else if (flags_wr) begin
      flags_q <= flags_in_i;
    end
  end

  // Memory request: captured at accept and held stable until the ack edge
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_dest_q  <= '0;
    end else if (mem_load) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= (op_code_i == 4'b1110);
      mem_addr_q  <= result_i[ADDR_W-1:0];
      mem_wdata_q <= store_data_i;
      mem_dest_q  <= dest_i;
    end else if (state_q == S_MEM && mem_ack_i) begin
      mem_req_q <= 1'b0;
    end
  end

  // Combinational read ports and flags, optionally bypassing the commit in flight
  always_comb begin
    rd_data_a_o = idx_ok(rd_addr_a_i) ? regs_q[rd_addr_a_i] : '0;
    rd_data_b_o = idx_ok(rd_addr_b_i) ? regs_q[rd_addr_b_i] : '0;
    flags_out_o = flags_q;
`ifdef WB_FORWARDING_EN
    if (wr_en && wr_idx == rd_addr_a_i) begin
      rd_data_a_o = wr_data;
    end
    if (wr_en && wr_idx == rd_addr_b_i) begin
      rd_data_b_o = wr_data;
    end
    if (flags_wr) begin
      flags_out_o = flags_in_i;
    end
`endif
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_code;
  logic [3:0]  dest;
  logic [31:0] result;
  logic [31:0] store_data;
  logic        reg_write;
  logic [3:0]  flags_in;
  logic        flags_update;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [3:0]  flags_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  // Reference state
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags = 4'b0;
  logic        m_busy  = 1'b0;
  logic        m_we    = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_dest  = '0;

  writeback_stage dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_code_i(op_code), .dest_i(dest), .result_i(result), .store_data_i(store_data),
    .reg_write_i(reg_write), .flags_in_i(flags_in), .flags_update_i(flags_update),
    .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
    .rd_data_a_o(rd_data_a), .rd_data_b_o(rd_data_b), .flags_out_o(flags_out),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic writes_reg(input logic [3:0] op);
    return !(op == 4'd11 || op == 4'd13 || op == 4'd14 || op == 4'd15);
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return (op <= 4'd2) || (op >= 4'd8 && op <= 4'd11);
  endfunction

  // Model update on each rising edge from the inputs present at that edge
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_flags = 4'b0; m_busy = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_dest = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        if (flags_update && sets_flags(op_code)) m_flags = flags_in;
        if (op_code == 4'd13 || op_code == 4'd14) begin
          m_busy  = 1'b1;
          m_we    = (op_code == 4'd14);
          m_addr  = result[15:0];
          m_wdata = store_data;
          m_dest  = dest;
        end else if (reg_write && writes_reg(op_code)) begin
          m_regs[dest] = result;
        end
      end
    end else if (mem_ack) begin
      m_busy = 1'b0;
      if (!m_we) m_regs[m_dest] = mem_rdata;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    logic [31:0] v;
    v = m_regs[a];
`ifdef WB_FORWARDING_EN
    if (!reset) begin
      if (!m_busy && in_valid && reg_write && writes_reg(op_code) && dest == a) v = result;
      if (m_busy && mem_ack && !m_we && m_dest == a) v = mem_rdata;
    end
`endif
    return v;
  endfunction

  function automatic logic [3:0] exp_flags();
    logic [3:0] f;
    f = m_flags;
`ifdef WB_FORWARDING_EN
    if (!reset && !m_busy && in_valid && flags_update && sets_flags(op_code)) f = flags_in;
`endif
    return f;
  endfunction

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("mem_req", mem_req, m_busy);
      if (m_busy) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("flags_out", flags_out, exp_flags());
      chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
      chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
    end
  end

  initial begin
    logic [31:0] fwd_exp;
    reset = 1'b1; in_valid = 1'b0; op_code = '0; dest = '0; result = '0; store_data = '0;
    reg_write = 1'b0; flags_in = '0; flags_update = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    check_en = 1'b1;
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_flags", flags_out, 4'h0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      #1;
      chk("rst_reg", rd_data_a, 32'h0);
    end
    step();

    // ALU write then compare
    in_valid = 1'b1; op_code = 4'd0; dest = 4'd3; result = 32'h7; reg_write = 1'b1;
    flags_update = 1'b1; flags_in = 4'b0000;
    step();
    in_valid = 1'b0; rd_addr_a = 4'd3;
    #1;
    chk("alu_reg3", rd_data_a, 32'h7);
    chk("alu_flags", flags_out, 4'b0000);
    in_valid = 1'b1; op_code = 4'd11; result = 32'h99; flags_in = 4'b0100;
    step();
    in_valid = 1'b0;
    #1;
    chk("cmp_flags", flags_out, 4'b0100);
    chk("cmp_reg3", rd_data_a, 32'h7);

    // Store with ack on the third request cycle
    in_valid = 1'b1; op_code = 4'd14; result = 32'h0010; store_data = 32'hDEADBEEF;
    flags_update = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("st_req", mem_req, 1'b1);
      chk("st_we", mem_we, 1'b1);
      chk("st_addr", mem_addr, 16'h0010);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st_in_ready", in_ready, 1'b0);
      if (k == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("st_done_ready", in_ready, 1'b1);
    chk("st_done_req", mem_req, 1'b0);

    // Load acked in the first request cycle
    in_valid = 1'b1; op_code = 4'd13; dest = 4'd5; result = 32'h0010;
    step();
    in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    chk("ld_req", mem_req, 1'b1);
    chk("ld_we", mem_we, 1'b0);
    chk("ld_in_ready", in_ready, 1'b0);
    step();
    mem_ack = 1'b0; rd_addr_a = 4'd5;
    #1;
    chk("ld_reg5", rd_data_a, 32'h12345678);
    chk("ld_done_ready", in_ready, 1'b1);

    // Reset during a pending load, then a stray ack
    in_valid = 1'b1; op_code = 4'd13; dest = 4'd5; result = 32'h0020;
    step();
    in_valid = 1'b0;
    chk("ab_req", mem_req, 1'b1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    reset = 1'b0; mem_rdata = 32'h00000055;
    #1;
    chk("ab_req_low", mem_req, 1'b0);
    chk("ab_reg5", rd_data_a, 32'h0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("stray_reg5", rd_data_a, 32'h0);
    chk("stray_ready", in_ready, 1'b1);

    // Same-cycle read of a register being written
    in_valid = 1'b1; op_code = 4'd0; dest = 4'd2; result = 32'hA5; reg_write = 1'b1;
    rd_addr_b = 4'd2;
`ifdef WB_FORWARDING_EN
    fwd_exp = 32'hA5;
`else
    fwd_exp = 32'h0;
`endif
    #1;
    chk("fwd_same", rd_data_b, fwd_exp);
    step();
    in_valid = 1'b0;
    #1;
    chk("fwd_next", rd_data_b, 32'hA5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      in_valid     = 1'($urandom_range(0, 1));
      op_code      = 4'($urandom);
      dest         = 4'($urandom);
      result       = $urandom;
      store_data   = $urandom;
      reg_write    = ($urandom_range(0, 3) != 0);
      flags_in     = 4'($urandom);
      flags_update = 1'($urandom_range(0, 1));
      rd_addr_a    = 4'($urandom);
      rd_addr_b    = 4'($urandom);
      mem_ack      = ($urandom_range(0, 2) == 0);
      mem_rdata    = $urandom;
      step();
    end
    reset = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
